// File: rtl/vid_fb_arb.sv
// vid_fb_arb: two-requester arbiter in front of one frame-buffer access port.
// One access in flight at a time: IDLE -> ISSUE (until fb_rdy_0) -> RESP (ack).
module vid_fb_arb #(
    parameter int AW = 14,
    parameter bit RR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          r0_req,
    input  logic [AW-1:0] r0_addr,
    input  logic [31:0]   r0_wdata,
    input  logic [3:0]    r0_wmsk,
    input  logic          r0_we,
    output logic          r0_ack,
    output logic [31:0]   r0_rdata,

    input  logic          r1_req,
    input  logic [AW-1:0] r1_addr,
    input  logic [31:0]   r1_wdata,
    input  logic [3:0]    r1_wmsk,
    input  logic          r1_we,
    output logic          r1_ack,
    output logic [31:0]   r1_rdata,

    output logic [AW-1:0] fb_addr_0,
    output logic [31:0]   fb_wdata_0,
    output logic [3:0]    fb_wmsk_0,
    output logic          fb_we_0,
    input  logic          fb_rdy_0,
    input  logic [31:0]   fb_rdata_1,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wmsk_q, wmsk_d;
    logic          we_q, we_d;

    logic          el0, el1;
    logic          win;

    // A requester whose ack is showing this cycle is not eligible again.
    always_comb begin
        el0 = r0_req & ~r0_ack;
        el1 = r1_req & ~r1_ack;
        if (el0 && el1) begin
            win = RR ? ~last_q : 1'b0;
        end else begin
            win = el1;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmsk_d  = wmsk_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (el0 || el1) begin
                    state_d = ISSUE;
                    gnt_d   = win;
                    addr_d  = win ? r1_addr  : r0_addr;
                    wdata_d = win ? r1_wdata : r0_wdata;
                    wmsk_d  = win ? r1_wmsk  : r0_wmsk;
                    we_d    = win ? r1_we    : r0_we;
                end
            end
            ISSUE: begin
                if (fb_rdy_0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = gnt_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            wmsk_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmsk_q  <= wmsk_d;
            we_q    <= we_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign fb_addr_0  = addr_q;
    assign fb_wdata_0 = wdata_q;
    assign fb_wmsk_0  = wmsk_q;
    assign fb_we_0    = (state_q == ISSUE) & we_q;

    // Read data is passed straight through from the port during the ack cycle.
    assign r0_ack   = (state_q == RESP) & ~gnt_q;
    assign r1_ack   = (state_q == RESP) & gnt_q;
    assign r0_rdata = r0_ack ? fb_rdata_1 : 32'h0;
    assign r1_rdata = r1_ack ? fb_rdata_1 : 32'h0;

endmodule
